prim_arbiter_rr_lock: RTL and testbench

//   N:1 round-robin arbiter with packet lock. Shares one downstream valid/ready sink between N

---
 rtl/prim_arbiter_rr_lock_pkg.sv | 16 +
 rtl/prim_arbiter_rr_lock_pick.sv | 35 +++
 rtl/prim_arbiter_rr_lock.sv | 123 ++++++++++++
 tb/tb_prim_arbiter_rr_lock.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/prim_arbiter_rr_lock_pkg.sv
// Shared types and helpers for the round-robin arbiters.
package prim_arbiter_pkg;

   typedef enum logic {
      ArbIdle   = 1'b0,
      ArbLocked = 1'b1
   } arb_state_e;

   // Next round-robin index with an explicit wrap, so non-power-of-2 port
   // counts never rely on counter overflow.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 1 >= n) return 0;
      return idx + 1;
   endfunction

endpackage

// File: rtl/prim_arbiter_rr_lock_pick.sv
// Combinational rotate-and-find-first: returns the first requesting index at
// or after ptr (mod N). The request vector is doubled so the wrapped scan is a
// plain linear search over 2N bits.
module prim_arbiter_rr_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [IdxW-1:0] idx,
   output logic            any
);

   localparam int unsigned PW = $clog2(2 * N);

   logic [2*N-1:0] req_dbl;

   assign req_dbl = {req, req};

   // Linear scan from ptr across the doubled vector, first hit wins.
   always_comb begin
      logic [PW-1:0] pos;
      idx = '0;
      any = 1'b0;
      pos = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = PW'(ptr) + PW'(i);
         if (!any && req_dbl[pos]) begin
            any = 1'b1;
            idx = (pos >= PW'(N)) ? IdxW'(pos - PW'(N)) : IdxW'(pos);
         end
      end
   end

endmodule

// File: rtl/prim_arbiter_rr_lock.sv
// N:1 round-robin arbiter with packet lock: a winner whose beat is not the
// last keeps the grant until its last beat is accepted.
module prim_arbiter_rr_lock
   import prim_arbiter_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned DW         = 32,
   parameter bit          EnDataPort = 1'b1,
   localparam int unsigned IdxW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N-1:0]    req_i,
   input  logic [DW-1:0]   data_i [N],
   input  logic [N-1:0]    last_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o,
   output logic [DW-1:0]   data_o,
   output logic            last_o,
   input  logic            ready_i,
   output logic            locked_o
);

   logic [IdxW-1:0] sel_idx;
   logic            sel_valid;
   logic            hs;

   assign idx_o   = sel_idx;
   assign valid_o = sel_valid;
   assign last_o  = sel_valid & last_i[sel_idx];
   assign hs      = sel_valid & ready_i;

   // Grant is the handshake, routed to the selected port only.
   always_comb begin
      gnt_o = '0;
      if (hs) gnt_o[sel_idx] = 1'b1;
   end

   if (N == 1) begin : g_bypass
      assign sel_idx   = '0;
      assign sel_valid = req_i[0];
      assign locked_o  = 1'b0;
   end else begin : g_arb
      arb_state_e      st_q;
      logic [IdxW-1:0] ptr_q;
      logic [IdxW-1:0] lock_idx_q;
      logic [IdxW-1:0] pick_idx;
      logic            pick_any;

      prim_arbiter_rr_pick #(
         .N    (N),
         .IdxW (IdxW)
      ) u_pick (
         .req (req_i),
         .ptr (ptr_q),
         .idx (pick_idx),
         .any (pick_any)
      );

      // While locked, only the owning port may be selected; a bubble on it
      // drops valid rather than letting another port in.
      always_comb begin
         sel_idx   = pick_idx;
         sel_valid = pick_any;
         if (st_q == ArbLocked) begin
            sel_idx   = lock_idx_q;
            sel_valid = req_i[lock_idx_q];
         end
      end

      // Lock/pointer state advances only on an accepted beat.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            st_q       <= ArbIdle;
            ptr_q      <= '0;
            lock_idx_q <= '0;
         end else if (hs) begin
            case (st_q)
               ArbIdle: begin
                  if (last_o) begin
                     ptr_q <= IdxW'(rr_next(32'(sel_idx), N));
                  end else begin
                     st_q       <= ArbLocked;
                     lock_idx_q <= sel_idx;
                  end
               end
               ArbLocked: begin
                  if (last_o) begin
                     st_q  <= ArbIdle;
                     ptr_q <= IdxW'(rr_next(32'(lock_idx_q), N));
                  end
               end
               default: st_q <= ArbIdle;
            endcase
         end
      end

      assign locked_o = (st_q == ArbLocked);

      a_lock_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
         locked_o |-> (idx_o == lock_idx_q));
   end

   if (EnDataPort) begin : g_data
      assign data_o = data_i[sel_idx];
   end else begin : g_no_data
      assign data_o = '1;
   end

   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_o));
   a_gnt_hs: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (|gnt_o) |-> (ready_i && valid_o));
   a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({valid_o, gnt_o, idx_o, locked_o}));

   for (genvar p = 0; p < N; p++) begin : g_hold
      a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (req_i[p] && !gnt_o[p]) |=> req_i[p]);
   end

endmodule

// File: tb/tb_prim_arbiter_rr_lock.sv
// Bench for prim_arbiter_rr_lock: N=4 table of cycle vectors checked through a
// scoreboard, plus a short N=3 wrap sequence.
module tb_prim_arbiter_rr_lock;

   logic        clk;
   logic        rst_n;

   logic [3:0]  req4, last4, gnt4;
   logic [31:0] data4 [4];
   logic [1:0]  idx4;
   logic        valid4, dlast4, ready4, locked4;
   logic [31:0] dout4;

   logic [2:0]  req3, last3, gnt3;
   logic [31:0] data3 [3];
   logic [1:0]  idx3;
   logic        valid3, dlast3, ready3, locked3;
   logic [31:0] dout3;

   prim_arbiter_rr_lock #(.N(4), .DW(32), .EnDataPort(1'b1)) dut (
      .clk_i (clk), .rst_ni (rst_n), .req_i (req4), .data_i (data4), .last_i (last4),
      .gnt_o (gnt4), .idx_o (idx4), .valid_o (valid4), .data_o (dout4), .last_o (dlast4),
      .ready_i (ready4), .locked_o (locked4)
   );

   prim_arbiter_rr_lock #(.N(3), .DW(32), .EnDataPort(1'b1)) dut3 (
      .clk_i (clk), .rst_ni (rst_n), .req_i (req3), .data_i (data3), .last_i (last3),
      .gnt_o (gnt3), .idx_o (idx3), .valid_o (valid3), .data_o (dout3), .last_o (dlast3),
      .ready_i (ready3), .locked_o (locked3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] last;
      logic       ready;
      logic [3:0] eg;
      logic [1:0] ei;
      logic       ev;
      logic       elk;
      logic       el;
   } vec_t;

   typedef struct {
      logic [3:0]  g;
      logic [1:0]  i;
      logic        v;
      logic        lk;
      logic        l;
      logic [31:0] d;
      int unsigned row;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic logic [31:0] dpat(input int unsigned p);
      return 32'hD000_0000 + p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] last,
                      input logic rdy, input logic [3:0] eg, input logic [1:0] ei,
                      input logic ev, input logic elk, input logic el);
      vec_t v;
      v.rst = rst; v.req = req; v.last = last; v.ready = rdy;
      v.eg = eg; v.ei = ei; v.ev = ev; v.elk = elk; v.el = el;
      vecs.push_back(v);
   endtask

   task automatic add_reset();
      add(1'b1, 4'h0, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard consumer: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check($sformatf("row%0d ctl{gnt,idx,valid,locked,last}", e.row),
               64'({gnt4, idx4, valid4, locked4, dlast4}),
               64'({e.g, e.i, e.v, e.lk, e.l}));
         check($sformatf("row%0d data", e.row), 64'(dout4), 64'(e.d));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t x;
      rst_n  = 1'b0;
      req4   = '0; last4 = '0; ready4 = 1'b0;
      req3   = '0; last3 = '0; ready3 = 1'b0;
      for (int p = 0; p < 4; p++) data4[p] = dpat(p);
      for (int p = 0; p < 3; p++) data3[p] = 32'hC000_0000 + p;

      // Reset state, then equal-priority single-beat rotation.
      add_reset();
      for (int k = 0; k < 8; k++)
         add(1'b0, 4'hF, 4'hF, 1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0, 1'b1);
      // Sparse requesters 0 and 2.
      add_reset();
      add(1'b0, 4'h5, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'h5, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'h5, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'h5, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
      // Three-beat packet on port 1 with everyone requesting.
      add_reset();
      add(1'b0, 4'hF, 4'hD, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'hF, 4'hD, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 4'hF, 4'hD, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
      add(1'b0, 4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
      add(1'b0, 4'hF, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
      // Lock on port 2, backpressure, bubble, release.
      add_reset();
      add(1'b0, 4'h4, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++)
         add(1'b0, 4'hF, 4'h0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
      add(1'b0, 4'hF, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
      add(1'b0, 4'hB, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
      add(1'b0, 4'hF, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
      add(1'b0, 4'hF, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      // Reset asserted mid-packet on port 3.
      add_reset();
      add(1'b0, 4'h8, 4'h0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
      add(1'b0, 4'hA, 4'h0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
      add(1'b1, 4'hA, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'hA, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'hA, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);

      @(posedge clk); #1;
      for (int unsigned r = 0; r < vecs.size(); r++) begin
         rst_n  = !vecs[r].rst;
         req4   = vecs[r].req;
         last4  = vecs[r].last;
         ready4 = vecs[r].ready;
         x.g = vecs[r].eg; x.i = vecs[r].ei; x.v = vecs[r].ev;
         x.lk = vecs[r].elk; x.l = vecs[r].el; x.d = dpat(vecs[r].ei); x.row = r;
         sb.push_back(x);
         @(posedge clk); #1;
      end
      check("scoreboard drained", 64'(sb.size()), 64'd0);

      // N=3: drive pointer to 2, grant 2, then the scan must wrap to 0.
      req4 = '0; last4 = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; req3 = 3'b010; last3 = 3'b111; ready3 = 1'b1;
      @(negedge clk);
      check("n3 gnt port1", 64'({gnt3, idx3}), 64'({3'b010, 2'd1}));
      @(posedge clk); #1;
      req3 = 3'b111;
      @(negedge clk);
      check("n3 gnt port2", 64'({gnt3, idx3}), 64'({3'b100, 2'd2}));
      check("n3 data port2", 64'(dout3), 64'(32'hC000_0002));
      @(posedge clk); #1;
      @(negedge clk);
      check("n3 wrap to port0", 64'({gnt3, idx3, locked3}), 64'({3'b001, 2'd0, 1'b0}));
      @(posedge clk); #1;
      @(negedge clk);
      check("n3 then port1", 64'({gnt3, idx3}), 64'({3'b010, 2'd1}));
      @(posedge clk); #1;
      req3 = '0;
      @(negedge clk);
      check("n3 idle", 64'({gnt3, valid3, dlast3}), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
